// File: rtl/bps_pkg.sv
// Shared opcode encoding for the bps engine and the sequencer FSM state encoding.
package bps_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned STEP_W   = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_IDLE       = 3'd0;
    localparam opcode_t OP_LOAD       = 3'd1;
    localparam opcode_t OP_DOWN       = 3'd2;
    localparam opcode_t OP_UP         = 3'd3;
    localparam opcode_t OP_STORE_DOWN = 3'd4;
    localparam opcode_t OP_STORE_UP   = 3'd5;

    localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap,
        StWait
    } state_e;

endpackage

// File: rtl/bps_master_sched.sv
// Step index to engine opcode lookup for one down/up sweep (6 steps).
module bps_master_sched
    import bps_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output opcode_t           op
);

    always_comb begin
        op = OP_IDLE;
        case (step)
            3'd0:    op = OP_LOAD;
            3'd1:    op = OP_DOWN;
            3'd2:    op = OP_STORE_DOWN;
            3'd3:    op = OP_LOAD;
            3'd4:    op = OP_UP;
            3'd5:    op = OP_STORE_UP;
            default: op = OP_IDLE;
        endcase
    end

endmodule

// File: rtl/bps_master_ctrl.sv
// BP-S engine sequencer: issues the sweep schedule ITERATIONS times, paced by bps_stall.
// Optional run trace enabled by defining BPS_MASTER_CTRL_TRACE_EN.
module bps_master_ctrl
    import bps_pkg::*;
#(
    parameter int unsigned ITERATIONS = 4,
    parameter int unsigned ITER_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                stall,
    output logic [OPCODE_W-1:0] opcode,
    input  logic                bps_stall
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d, step_inc, sched_idx;
    logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
    opcode_t             opcode_q, opcode_d, sched_op;
    logic                stall_q, stall_d;
    logic                last_step;

    assign last_step = (step_q == LAST_STEP) && (iter_q == ITER_W'(ITERATIONS - 1));
    assign step_inc  = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
    assign iter_inc  = (step_q == LAST_STEP) ? iter_q + ITER_W'(1) : iter_q;
    // Idle looks up step 0 so the first opcode is registered on the start edge.
    assign sched_idx = (state_q == StIdle) ? '0 : step_inc;

    bps_master_sched u_sched (
        .step (sched_idx),
        .op   (sched_op)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        iter_d   = iter_q;
        opcode_d = opcode_q;
        stall_d  = stall_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StIssue;
                    step_d   = '0;
                    iter_d   = '0;
                    opcode_d = sched_op;
                    stall_d  = 1'b1;
                end
            end
            StIssue: begin
                if (!bps_stall) begin
                    state_d  = StGap;
                    opcode_d = OP_IDLE;
                end
            end
            StGap: begin
                // The final step always passes through Wait, where the run completes.
                if (!bps_stall && !last_step) begin
                    state_d  = StIssue;
                    step_d   = step_inc;
                    iter_d   = iter_inc;
                    opcode_d = sched_op;
                end else begin
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (!bps_stall) begin
                    if (last_step) begin
                        state_d = StIdle;
                        step_d  = '0;
                        iter_d  = '0;
                        stall_d = 1'b0;
                    end else begin
                        state_d  = StIssue;
                        step_d   = step_inc;
                        iter_d   = iter_inc;
                        opcode_d = sched_op;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                step_d   = '0;
                iter_d   = '0;
                opcode_d = OP_IDLE;
                stall_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            iter_q   <= '0;
            opcode_q <= OP_IDLE;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            iter_q   <= iter_d;
            opcode_q <= opcode_d;
            stall_q  <= stall_d;
        end
    end

    assign stall  = stall_q;
    assign opcode = opcode_q;

`ifdef BPS_MASTER_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (rst && state_q == StIssue && !bps_stall) begin
            $display("%0t bps_master_ctrl: iter %0d step %0d opcode %0d",
                     $time, iter_q, step_q, opcode_q);
        end
        if (rst && state_q == StWait && !bps_stall && last_step) begin
            $display("%0t bps_master_ctrl: run complete", $time);
        end
    end
`endif

endmodule

// File: tb/tb_bps_master_ctrl.sv
// Scoreboard bench for bps_master_ctrl with a behavioural engine model driving bps_stall.
module tb_bps_master_ctrl;

    localparam int unsigned ITERS  = 3;
    localparam int unsigned ITER_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stall;
    logic [2:0] opcode;
    logic       bps_stall = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int busy_len   = 0;
    int busy_rem   = 0;
    int hold_rem   = 0;
    int accepts    = 0;
    int run_cycles = 0;
    int zero_run   = 0;
    int exp_gap    = 1;
    int op2_cycles = 0;
    logic [2:0] sb[$];

    bps_master_ctrl #(
        .ITERATIONS (ITERS),
        .ITER_W     (ITER_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .opcode    (opcode),
        .bps_stall (bps_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Engine model: decides bps_stall for the coming edge, then scores any accept.
    always @(negedge clk) begin : engine
        logic       s;
        logic [2:0] e;
        if (!rst) begin
            bps_stall = 1'b0;
            busy_rem  = 0;
            zero_run  = 0;
        end else begin
            s = 1'b0;
            if (busy_rem > 0) begin
                s = 1'b1;
                busy_rem--;
            end else if (opcode == 3'd2 && hold_rem > 0) begin
                s = 1'b1;
                hold_rem--;
            end
            bps_stall = s;
            if (stall) run_cycles++;
            if (opcode == 3'd2) op2_cycles++;
            if (!stall) begin
                zero_run = 0;
            end else if (opcode == 3'd0) begin
                zero_run++;
            end else begin
                if (zero_run > 0) check_eq("gap", zero_run, exp_gap);
                zero_run = 0;
                if (!s) begin
                    accepts++;
                    busy_rem = busy_len;
                    if (sb.size() == 0) begin
                        check_eq("accept_extra", int'(opcode), 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("opcode", int'(opcode), int'(e));
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_start();
        logic [2:0] sched [6];
        sched = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd3, 3'd5};
        sb.delete();
        for (int it = 0; it < int'(ITERS); it++) begin
            for (int k = 0; k < 6; k++) sb.push_back(sched[k]);
        end
        accepts    = 0;
        run_cycles = 0;
        op2_cycles = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_stall", int'(stall), 1);
        check_eq("start_opcode", int'(opcode), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (!stall) break;
            step();
        end
        check_eq("run_timeout", int'(stall), 0);
        check_eq("sb_left", sb.size(), 0);
        check_eq("accepts", accepts, 6 * int'(ITERS));
    endtask

    initial begin
        // Reset held with start asserted.
        rst   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_stall", int'(stall), 0);
            check_eq("rst_opcode", int'(opcode), 0);
        end
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_stall", int'(stall), 0);
            check_eq("post_rst_opcode", int'(opcode), 0);
        end

        // Always-ready engine.
        busy_len = 0;
        exp_gap  = 1;
        run_start();
        wait_done();
        check_eq("ready_len", run_cycles, 1 + 12 * int'(ITERS));

        // Engine busy five cycles after each accept.
        step();
        busy_len = 5;
        exp_gap  = 6;
        run_start();
        wait_done();
        check_eq("busy_len", run_cycles, 42 * int'(ITERS));

        // bps_stall held on the first DOWN issue cycle.
        step();
        busy_len = 0;
        exp_gap  = 1;
        hold_rem = 3;
        run_start();
        wait_done();
        check_eq("hold_down_cycles", op2_cycles, 3 + int'(ITERS));
        check_eq("hold_len", run_cycles, 4 + 12 * int'(ITERS));

        // Re-trigger mid-run and in the completion cycle.
        step();
        run_start();
        for (int i = 0; i < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (accepts >= 6 * int'(ITERS) || !stall) break;
            step();
        end
        step();
        step();
        check_eq("final_wait_stall", int'(stall), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("retrig_done", int'(stall), 0);
        for (int i = 0; i < 4; i++) step();
        check_eq("retrig_idle_stall", int'(stall), 0);
        check_eq("retrig_idle_opcode", int'(opcode), 0);
        check_eq("retrig_accepts", accepts, 6 * int'(ITERS));
        check_eq("retrig_sb_left", sb.size(), 0);

        // Asynchronous reset during the UP step of iteration 2.
        step();
        run_start();
        for (int i = 0; i < 3000; i++) begin
            if (opcode == 3'd3 && accepts == 17) break;
            step();
        end
        check_eq("reach_up_it2", int'(opcode), 3);
        rst = 1'b0;
        #1;
        check_eq("midrst_stall", int'(stall), 0);
        check_eq("midrst_opcode", int'(opcode), 0);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        check_eq("midrst_idle", int'(stall), 0);
        run_start();
        wait_done();
        check_eq("restart_len", run_cycles, 1 + 12 * int'(ITERS));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
